// File: rtl/mont_pkg.sv
// Shared definitions for the modular-exponentiation sequencer: default width,
// FSM state encoding and the constant used for the Montgomery-domain exit.
package mont_pkg;

    localparam int N_DEFAULT = 512;

    typedef enum logic [3:0] {
        IDLE,
        SQ_ISSUE,
        SQ_WAIT,
        MUL_ISSUE,
        MUL_WAIT,
        NEXT,
        CONV_ISSUE,
        CONV_WAIT,
        FIN
    } state_e;

    localparam logic [N_DEFAULT-1:0] ONE_N = N_DEFAULT'(1);

endpackage

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery core.
// Define MONT_EXP_FROM_MONT_EN to append a final multiply-by-one that leaves the result in the normal domain.
module mont_exp_ctrl
    import mont_pkg::*;
#(
    parameter int N       = N_DEFAULT,
    parameter int E_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N-1:0]       in_x,
    input  logic [N-1:0]       in_one,
    input  logic [N-1:0]       in_m,
    input  logic [E_WIDTH-1:0] in_e,
    output logic [N-1:0]       result,
    output logic               done,
    output logic               busy,
    output logic               mm_start,
    output logic [N-1:0]       mm_in_a,
    output logic [N-1:0]       mm_in_b,
    output logic [N-1:0]       mm_in_m,
    input  logic [N-1:0]       mm_result,
    input  logic               mm_done
);

    localparam int IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

    state_e             state_q;
    logic [N-1:0]       acc_q;
    logic [N-1:0]       x_q;
    logic [E_WIDTH-1:0] e_q;
    logic [IW-1:0]      idx_q;
    logic [N-1:0]       result_q;
    logic               done_q;
    logic               busy_q;
    logic               mm_start_q;
    logic [N-1:0]       mm_in_a_q;
    logic [N-1:0]       mm_in_b_q;
    logic [N-1:0]       mm_in_m_q;

    // Operands are loaded on the transition into each ISSUE state so that
    // mm_start and the operands appear together and stay put until mm_done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            x_q        <= '0;
            e_q        <= '0;
            idx_q      <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            mm_start_q <= 1'b0;
            mm_in_a_q  <= '0;
            mm_in_b_q  <= '0;
            mm_in_m_q  <= '0;
        end else begin
            mm_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q        <= in_x;
                        mm_in_m_q  <= in_m;
                        e_q        <= in_e;
                        acc_q      <= in_one;
                        idx_q      <= IW'(E_WIDTH - 1);
                        busy_q     <= 1'b1;
                        mm_start_q <= 1'b1;
                        mm_in_a_q  <= in_one;
                        mm_in_b_q  <= in_one;
                        state_q    <= SQ_ISSUE;
                    end
                end
                SQ_ISSUE: state_q <= SQ_WAIT;
                SQ_WAIT: begin
                    if (mm_done) begin
                        acc_q <= mm_result;
                        if (e_q[idx_q]) begin
                            mm_start_q <= 1'b1;
                            mm_in_a_q  <= mm_result;
                            mm_in_b_q  <= x_q;
                            state_q    <= MUL_ISSUE;
                        end else begin
                            state_q <= NEXT;
                        end
                    end
                end
                MUL_ISSUE: state_q <= MUL_WAIT;
                MUL_WAIT: begin
                    if (mm_done) begin
                        acc_q   <= mm_result;
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    if (idx_q == '0) begin
`ifdef MONT_EXP_FROM_MONT_EN
                        mm_start_q <= 1'b1;
                        mm_in_a_q  <= acc_q;
                        mm_in_b_q  <= N'(ONE_N);
                        state_q    <= CONV_ISSUE;
`else
                        result_q <= acc_q;
                        done_q   <= 1'b1;
                        state_q  <= FIN;
`endif
                    end else begin
                        idx_q      <= idx_q - IW'(1);
                        mm_start_q <= 1'b1;
                        mm_in_a_q  <= acc_q;
                        mm_in_b_q  <= acc_q;
                        state_q    <= SQ_ISSUE;
                    end
                end
`ifdef MONT_EXP_FROM_MONT_EN
                CONV_ISSUE: state_q <= CONV_WAIT;
                CONV_WAIT: begin
                    if (mm_done) begin
                        acc_q    <= mm_result;
                        result_q <= mm_result;
                        done_q   <= 1'b1;
                        state_q  <= FIN;
                    end
                end
`endif
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result   = result_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign mm_start = mm_start_q;
    assign mm_in_a  = mm_in_a_q;
    assign mm_in_b  = mm_in_b_q;
    assign mm_in_m  = mm_in_m_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench for mont_exp_ctrl with a behavioural Montgomery core of configurable latency.
// Expectations follow MONT_EXP_FROM_MONT_EN when it is defined.
`timescale 1ns/1ps
module tb_mont_exp_ctrl;

    localparam int     N   = 16;
    localparam int     EW  = 4;
    localparam longint MOD = 61453;
    localparam longint R   = 65536;
`ifdef MONT_EXP_FROM_MONT_EN
    localparam int FEAT = 1;
`else
    localparam int FEAT = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  inX = '0;
    logic [N-1:0]  inOne = '0;
    logic [N-1:0]  inM = '0;
    logic [EW-1:0] inE = '0;
    logic [N-1:0]  result;
    logic          done;
    logic          busy;
    logic          mmStart;
    logic [N-1:0]  mmInA;
    logic [N-1:0]  mmInB;
    logic [N-1:0]  mmInM;
    logic [N-1:0]  mmResult = '0;
    logic          mmDone;
    logic          modelDone = 1'b0;
    logic          injectDone = 1'b0;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            coreLat = 5;
    int            txnCount = 0;
    logic [31:0]   opLog = '0;
    logic [N-1:0]  xCur = '0;
    logic          pending = 1'b0;
    int            cnt = 0;
    logic [N-1:0]  resHold = '0;

    assign mmDone = modelDone | injectDone;

    mont_exp_ctrl #(.N(N), .E_WIDTH(EW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_x(inX), .in_one(inOne), .in_m(inM), .in_e(inE),
        .result(result), .done(done), .busy(busy),
        .mm_start(mmStart), .mm_in_a(mmInA), .mm_in_b(mmInB), .mm_in_m(mmInM),
        .mm_result(mmResult), .mm_done(mmDone)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bit-serial REDC: a*b*R^-1 mod m, independent of the modular-power reference below.
    function automatic logic [N-1:0] montMul(input logic [N-1:0] a, input logic [N-1:0] b,
                                              input logic [N-1:0] m);
        longint t;
        t = longint'(a) * longint'(b);
        for (int k = 0; k < N; k++) begin
            if (t[0]) t = t + longint'(m);
            t = t >>> 1;
        end
        if (t >= longint'(m)) t = t - longint'(m);
        return t[N-1:0];
    endfunction

    function automatic logic [1:0] opCode(input logic [N-1:0] a, input logic [N-1:0] b);
        if (a == b)             return 2'd1;
        else if (b == xCur)     return 2'd2;
        else if (b == N'(1))    return 2'd3;
        else                    return 2'd0;
    endfunction

    // Plain modular power, then mapped into the Montgomery domain unless the exit multiply is built in.
    function automatic longint refResult(input longint x, input logic [EW-1:0] e);
        longint v;
        v = 1;
        for (int i = EW - 1; i >= 0; i--) begin
            v = (v * v) % MOD;
            if (e[i]) v = (v * x) % MOD;
        end
        return (FEAT != 0) ? v : (v * R) % MOD;
    endfunction

    // Behavioural core: mm_done pulses coreLat cycles after the mm_start cycle.
    always @(posedge clk) begin
        modelDone <= 1'b0;
        if (pending) begin
            if (cnt <= 1) begin
                modelDone <= 1'b1;
                mmResult  <= resHold;
                pending   <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
        if (mmStart) begin
            txnCount <= txnCount + 1;
            opLog    <= {opLog[29:0], opCode(mmInA, mmInB)};
            if (coreLat == 1) begin
                modelDone <= 1'b1;
                mmResult  <= montMul(mmInA, mmInB, mmInM);
            end else begin
                resHold <= montMul(mmInA, mmInB, mmInM);
                pending <= 1'b1;
                cnt     <= coreLat - 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic loadOperands(input longint x, input logic [EW-1:0] e, input int lat);
        coreLat = lat;
        xCur    = N'((x * R) % MOD);
        inX     = xCur;
        inOne   = N'(R % MOD);
        inM     = N'(MOD);
        inE     = e;
    endtask

    task automatic applyStimulus(input longint x, input logic [EW-1:0] e, input int lat,
                                 output int latency, output int txns, output logic [31:0] ops);
        int base;
        int t0;
        int n;
        loadOperands(x, e, lat);
        base = txnCount;
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("doneSeen", longint'(done), 1);
        latency = cyc - t0;
        txns    = txnCount - base;
        ops     = opLog;
    endtask

    task automatic checkRun(input string tag, input longint x, input logic [EW-1:0] e, input int lat,
                            input logic [31:0] baseOps, input int latency, input int txns,
                            input logic [31:0] ops);
        int          expTx;
        logic [31:0] expOps;
        logic [31:0] mask;
        expTx  = EW + $countones(e) + FEAT;
        expOps = (FEAT != 0) ? {baseOps[29:0], 2'b11} : baseOps;
        mask   = (32'h1 << (2 * expTx)) - 32'h1;
        checkOutput({tag, "_result"}, longint'(result), refResult(x, e));
        checkOutput({tag, "_txns"}, longint'(txns), longint'(expTx));
        checkOutput({tag, "_latency"}, longint'(latency), longint'(expTx * (1 + lat) + EW + 1));
        checkOutput({tag, "_ops"}, longint'(ops & mask), longint'(expOps));
    endtask

    task automatic disturb();
        int n;
        n = 0;
        while (!mmStart && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!modelDone && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        injectDone = 1'b1;
        @(negedge clk);
        injectDone = 1'b0;
    endtask

    initial begin
        int          lat;
        int          txns;
        int          base;
        int          n;
        logic [31:0] ops;
        logic        lateSeen;

        repeat (2) @(negedge clk);
        checkOutput("rst_result", longint'(result), 0);
        checkOutput("rst_done_busy", longint'({done, busy, mmStart}), 0);
        checkOutput("rst_mm_ops", longint'({mmInA, mmInB}), 0);
        checkOutput("rst_mm_m", longint'(mmInM), 0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(1234, 4'b0000, 5, lat, txns, ops);
        checkRun("e0", 1234, 4'b0000, 5, 32'h55, lat, txns, ops);
        checkOutput("e0_result_is_one", longint'(result), (FEAT != 0) ? 1 : R % MOD);
        @(negedge clk);
        checkOutput("e0_idle_after", longint'({done, busy}), 0);

        applyStimulus(1234, 4'b0001, 5, lat, txns, ops);
        checkRun("e1", 1234, 4'b0001, 5, 32'h156, lat, txns, ops);

        applyStimulus(4321, 4'b1010, 3, lat, txns, ops);
        checkRun("e10", 4321, 4'b1010, 3, 32'h659, lat, txns, ops);

        applyStimulus(999, 4'b1111, 1, lat, txns, ops);
        checkRun("e15", 999, 4'b1111, 1, 32'h6666, lat, txns, ops);

        // Stray start during SQ_WAIT and a stray mm_done during NEXT must not disturb the run.
        fork
            applyStimulus(2468, 4'b0100, 4, lat, txns, ops);
            disturb();
        join
        checkRun("dist", 2468, 4'b0100, 4, 32'h165, lat, txns, ops);
        base = txnCount;
        repeat (10) @(negedge clk);
        checkOutput("dist_no_requeue", longint'(txnCount - base), 0);
        checkOutput("dist_idle", longint'(busy), 0);

        // Abort in MUL_WAIT; the core's late completion must be ignored.
        loadOperands(555, 4'b1000, 5);
        base = txnCount;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while ((txnCount - base) < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("abort_busy_before", longint'(busy), 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_async_ctrl", longint'({done, busy, mmStart}), 0);
        checkOutput("abort_async_data", longint'({result, mmInA, mmInB, mmInM}), 0);
        @(negedge clk);
        reset = 1'b0;
        lateSeen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (mmDone) lateSeen = 1'b1;
        end
        checkOutput("abort_late_done_seen", longint'(lateSeen), 1);
        checkOutput("abort_ignored", longint'({done, busy, mmStart}), 0);
        checkOutput("abort_result_kept", longint'(result), 0);
        checkOutput("abort_txns", longint'(txnCount - base), 2);

        applyStimulus(777, 4'b1010, 3, lat, txns, ops);
        checkRun("fresh", 777, 4'b1010, 3, 32'h659, lat, txns, ops);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
